// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: op codes, FSM states, iteration count.
package muldiv_pkg;

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_MULH   = 4'b1001;
  localparam logic [3:0] OP_MULHSU = 4'b1010;
  localparam logic [3:0] OP_MULHU  = 4'b1011;
  localparam logic [3:0] OP_DIV    = 4'b1100;
  localparam logic [3:0] OP_DIVU   = 4'b1101;
  localparam logic [3:0] OP_REM    = 4'b1110;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic signed_a(logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic signed_b(logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Results for divide-by-zero and signed overflow (-2^31 / -1).
  function automatic logic [31:0] special_result(logic is_rem, logic [31:0] dividend,
                                                 logic div_zero);
    if (div_zero) return is_rem ? dividend : 32'hFFFF_FFFF;
    return is_rem ? 32'h0000_0000 : 32'h8000_0000;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: shift-add multiply or restoring divide.
// Divide uses acc[2W-1:W] as remainder and acc[W-1:0] as the dividend/quotient.
module muldiv_step #(
  parameter int unsigned W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   operand_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0]   mul_sum;
  logic [W:0]   rem_sh;
  logic         rem_ge;
  logic [W-1:0] rem_diff;

  always_comb begin
    mul_sum  = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    rem_sh   = acc_i[2*W-1:W-1];
    rem_ge   = rem_sh >= {1'b0, operand_i};
    // When rem_ge holds the true difference is below the divisor, so W bits suffice.
    rem_diff = rem_sh[W-1:0] - operand_i;
    if (is_div) begin
      if (rem_ge) acc_o = {rem_diff, acc_i[W-2:0], 1'b1};
      else        acc_o = {acc_i[2*W-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit (33-cycle latency, one bit per cycle).
// Define MULDIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned W = DATA_WIDTH;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam bit FAST_SPECIAL = 1'b1;
`else
  localparam bit FAST_SPECIAL = 1'b0;
`endif

  state_t         state;
  logic [5:0]     count;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nx;
  logic [W-1:0]   operand_r;
  logic [W-1:0]   dividend_r;
  logic [3:0]     op_r;
  logic           neg_q;
  logic           neg_r;
  logic           special_r;

  logic           start_ok;
  logic           in_div;
  logic           in_sa;
  logic           in_sb;
  logic           in_div_zero;
  logic           in_ovf;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   final_res;

  always_comb begin
    start_ok    = start_i & alu_operation_i[3];
    in_div      = alu_operation_i[2];
    in_sa       = operand_a_i[W-1] & signed_a(alu_operation_i);
    in_sb       = operand_b_i[W-1] & signed_b(alu_operation_i);
    mag_a       = in_sa ? -operand_a_i : operand_a_i;
    mag_b       = in_sb ? -operand_b_i : operand_b_i;
    in_div_zero = in_div && (operand_b_i == '0);
    in_ovf      = in_div && signed_b(alu_operation_i) &&
                  (operand_a_i == {1'b1, {(W-1){1'b0}}}) && (operand_b_i == '1);
  end

  muldiv_step #(.W(W)) u_step (
    .is_div    (op_r[2]),
    .acc_i     (acc),
    .operand_i (operand_r),
    .acc_o     (acc_nx)
  );

  // Sign fix-up applied to the final iteration's output, ahead of the result register.
  always_comb begin
    prod_s = neg_q ? -acc_nx : acc_nx;
    quot_s = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
    rem_s  = neg_r ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
    if (special_r) begin
      final_res = special_result(op_r[1], dividend_r, operand_r == '0);
    end else begin
      unique case (op_r)
        OP_MUL:                       final_res = prod_s[W-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*W-1:W];
        OP_DIV, OP_DIVU:              final_res = quot_s;
        default:                      final_res = rem_s;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      acc        <= '0;
      operand_r  <= '0;
      dividend_r <= '0;
      op_r       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      special_r  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
          if (start_ok) begin
            op_r       <= alu_operation_i;
            operand_r  <= in_div ? mag_b : mag_a;
            acc        <= {{W{1'b0}}, (in_div ? mag_a : mag_b)};
            dividend_r <= operand_a_i;
            neg_q      <= in_sa ^ in_sb;
            neg_r      <= in_sa;
            special_r  <= in_div_zero | in_ovf;
            count      <= '0;
            if (FAST_SPECIAL && (in_div_zero || in_ovf)) begin
              state    <= S_DONE;
              done_o   <= 1'b1;
              result_o <= special_result(alu_operation_i[1], operand_a_i, in_div_zero);
            end else begin
              state  <= S_CALC;
              busy_o <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc   <= acc_nx;
          count <= count + 1'b1;
          if (count == 6'(ITER_COUNT - 1)) begin
            state    <= S_DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= final_res;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus randomized ops vs a reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i = 1'b0;
  logic [3:0]  op = 4'b0000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (op),
    .operand_a_i     (a),
    .operand_b_i     (b),
    .busy_o          (busy),
    .done_o          (done),
    .result_o        (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          busy;
    int          start;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          busy_cnt = 0;
  logic [31:0] prev_res = '0;

  function automatic logic [31:0] ref_model(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy, ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    case (o)
      OP_MUL:    begin p = sx * sy; return p[31:0];  end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      OP_MULHU:  begin p = ux * uy; return p[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(x) / $signed(y));
      end
      OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(x) % $signed(y));
      end
      OP_REMU: return (y == 0) ? x : x % y;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    return o[2] && ((y == 0) ||
           ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Caller must be at a negedge when b2b is set (issues within that same cycle).
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expv, input bit b2b);
    exp_t e;
    int   w = 0;
    if (!b2b) @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL issue_wait op=%h busy_o=%0b required=0", o, busy);
      return;
    end
    op = o; a = x; b = y; start_i = 1'b1;
    @(posedge clk);
    #1;
    e.res   = expv;
    e.lat   = (FAST && is_special(o, x, y)) ? 1 : 33;
    e.busy  = (FAST && is_special(o, x, y)) ? 0 : 32;
    e.start = cyc;
    e.op    = o;
    sb.push_back(e);
    start_i = 1'b0;
    op = 4'($urandom_range(8, 15));
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_done();
    int w = 0;
    @(negedge clk);
    while (!done && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL wait_done done_o=%0b required=1", done);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done_o and checks result, latency and busy length.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL spurious_done result=%h required=no_done", result);
        end else begin
          mon_e = sb.pop_front();
          if (result !== mon_e.res || (cyc - mon_e.start + 1) != mon_e.lat ||
              busy_cnt != mon_e.busy) begin
            fails++;
            $display("FAIL op_%h result=%h required=%h latency=%0d required=%0d busy=%0d required=%0d",
                     mon_e.op, result, mon_e.res, cyc - mon_e.start + 1, mon_e.lat,
                     busy_cnt, mon_e.busy);
          end
        end
        busy_cnt = 0;
      end else begin
        tests++;
        if (result !== prev_res) begin
          fails++;
          $display("FAIL result_hold actual=%h required=%h", result, prev_res);
        end
      end
    end
    prev_res = result;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time_limit_reached pending=%0d", sb.size());
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    reset = 1'b1;

    issue(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    issue(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    issue(OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    issue(OP_MULHSU, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 1'b0);
    issue(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    issue(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    issue(OP_DIVU,   32'd100,        32'd7,         32'd14,        1'b0);
    issue(OP_REMU,   32'd100,        32'd7,         32'd2,         1'b0);
    issue(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0);
    issue(OP_REM,    32'd5,          32'd0,         32'd5,         1'b0);
    issue(OP_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF, 1'b0);
    issue(OP_REMU,   32'd9,          32'd0,         32'd9,         1'b0);
    issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0);
    issue(OP_MUL,    32'd0,          32'd0,         32'h0,         1'b0);
    drain();

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(OP_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0);
    wait_done();
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b1);
    wait_done();
    issue(OP_REM, 32'd7, 32'd0, 32'd7, 1'b1);
    drain();

    // Start during CALC must be ignored.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (5) @(negedge clk);
    op = OP_MUL; a = 32'd3; b = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    drain();

    // Non-M code in IDLE must be ignored.
    @(negedge clk);
    op = 4'b0000; a = 32'd6; b = 32'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("invalid_code_busy", {31'b0, busy}, 32'h0);
    repeat (40) @(negedge clk);

    // Reset mid-DIVU aborts with no done.
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd13, 32'hDEAD_BEEF / 32'd13, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_result", result, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(OP_REMU, 32'hDEAD_BEEF, 32'd13, 32'hDEAD_BEEF % 32'd13, 1'b0);
    drain();

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(8, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'($signed(-$urandom_range(1, 50)));
        default: ;
      endcase
      issue(ro, ra, rb, ref_model(ro, ra, rb), 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide execution unit. It sits downstream of the ALU control decoder and consumes its 4-bit operation code whenever that code selects an M-extension operation. It accepts one operation per start/done handshake. Multiplication is iterative shift-add and division is restoring; each runs one bit per cycle. It returns a 32-bit result to the writeback mux.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only when busy_o=0.
- alu_operation_i  input  4  operation code from the ALU control decoder.
- operand_a_i  input  DATA_WIDTH  rs1 value (multiplicand/dividend).
- operand_b_i  input  DATA_WIDTH  rs2 value (multiplier/divisor).
- busy_o  output  1  high while an operation is in flight.
- done_o  output  1  single-cycle pulse; result_o is valid.
- result_o  output  DATA_WIDTH  registered result, held until the next completion.

## Operation
- Accepted codes: MUL 4'b1000, MULH 4'b1001, MULHSU 4'b1010, MULHU 4'b1011, DIV 4'b1100, DIVU 4'b1101, REM 4'b1110, REMU 4'b1111.
- A start_i with code below 4'b1000 is ignored; state does not change.
- States:
  - IDLE: busy_o=0. A valid start goes to CALC.
  - CALC: busy_o=1. A 6-bit counter runs 0..31. When the counter equals 31, go to DONE.
  - DONE: done_o=1, busy_o=0. A valid start goes straight to CALC; otherwise go to IDLE.
- Operands, op code and signedness are latched on acceptance. Later input changes have no effect.
- Signed ops:
  - Magnitudes are taken at acceptance and the unsigned core runs on them.
  - Result sign is fixed on the last CALC cycle before the result register is written.
  - MULHSU treats only operand_a as signed.
- Multiply: 64-bit product accumulator. MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].
- Divide: 32-bit quotient and remainder registers. Quotient and remainder follow RISC-V truncation semantics: the remainder takes the dividend's sign.
- Divide by zero:
  - DIV/DIVU return 32'hFFFF_FFFF.
  - REM/REMU return the dividend.
- Signed overflow (32'h8000_0000 / 32'hFFFF_FFFF):
  - DIV returns 32'h8000_0000.
  - REM returns 0.
- start_i while in CALC is ignored and not queued.

## Timing
- Reset values: busy_o=0, done_o=0, result_o=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. No done_o pulse follows.
- Start sampled at edge N:
  - busy_o is high for cycles N+1..N+32.
  - done_o and the new result_o appear in cycle N+33.
- Latency is 33 cycles, identical for all eight ops unless the configuration macro below is defined.
- Back-to-back: a start in the DONE cycle gives the next done_o 33 cycles later. Maximum throughput is one op per 33 cycles.
- result_o changes only on the cycle done_o rises.

## Configuration
- MULDIV_FAST_SPECIAL_EN
  - Defined: divide-by-zero and signed-overflow cases skip CALC. Acceptance goes directly to DONE, so done_o appears at N+1. Multiplication by zero is not shortcut.
  - Undefined: all cases take the full 33-cycle path and produce the same result values.

## Structure
- Shared package muldiv_pkg holds:
  - The eight op-code localparams, shared with the ALU control decoder.
  - The state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10).
  - The iteration count constant 32.
- One sub-module, muldiv_step: combinational single-iteration datapath. It performs a conditional add-and-shift for multiply and a trial-subtract-and-shift for divide. The top-level holds the FSM, counter, sign fix-up and registers.

## Test plan
- MUL: 7 × -3 (32'hFFFF_FFFD) -> result_o=32'hFFFF_FFEB; done_o exactly 33 cycles after start; busy_o high for 32 cycles.
- MULH / MULHU / MULHSU, all with 32'h8000_0000 × 32'h8000_0000:
  - MULH -> 32'h4000_0000.
  - MULHU -> 32'h4000_0000.
  - MULHSU -> 32'hC000_0000.
- DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5.
  - DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM same operands -> 0.
  - Latency is 33 cycles without the macro and 1 cycle with MULDIV_FAST_SPECIAL_EN defined.
- Handshake:
  - start_i pulsed during CALC and with code 4'b0000 in IDLE -> ignored; no extra done_o.
  - start in the DONE cycle -> second done_o 33 cycles later.
- Reset:
  - reset low at cycle 10 of a DIVU -> outputs return to 0 immediately; no done_o.
  - Next op after reset completes correctly.
